// File: rtl/led_arbiter_if.sv
// rtl/led_arbiter_if.sv - request/pattern/grant bundle between pattern sources and led_arbiter
interface led_arbiter_if #(
  parameter int LED_W = 6
);
  logic [3:0]         in_req;
  logic [4*LED_W-1:0] in_pat;
  logic [3:0]         out_gnt;
  logic [LED_W-1:0]   out_led;
  logic               out_busy;

  modport master (
    output in_req,
    output in_pat,
    input  out_gnt,
    input  out_led,
    input  out_busy
  );

  modport slave (
    input  in_req,
    input  in_pat,
    output out_gnt,
    output out_led,
    output out_busy
  );
endinterface

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - round-robin LED bank arbiter with minimum hold time
// Optional LED_ARB_ACTIVE_LOW_EN inverts out_led (including idle and reset values).
module led_arbiter #(
  parameter int               HOLD_CYCLES  = 2700000,
  parameter int               LED_W        = 6,
  parameter logic [LED_W-1:0] IDLE_PATTERN = {LED_W{1'b0}}
) (
  input logic          in_clk,
  input logic          in_rst,
  led_arbiter_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

`ifdef LED_ARB_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0] LED_XOR = {LED_W{1'b1}};
`else
  localparam logic [LED_W-1:0] LED_XOR = {LED_W{1'b0}};
`endif

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [1:0]       last, last_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic             rr_valid;
  logic [1:0]       rr_idx;
  logic [1:0]       cand;
  logic [3:0]       other_req;
  logic [LED_W-1:0] led_sel;
  logic [LED_W-1:0] led_nxt;
  logic [3:0]       gnt_nxt;
  logic             busy_nxt;

  // Scan from last+4 down to last+1 so the nearest successor of last wins.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = last;
    cand     = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (bus.in_req[cand]) begin
        rr_valid = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign other_req = bus.in_req & ~(4'(1) << owner);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    hold_nxt  = (hold_cnt != '0) ? hold_cnt - HW'(1) : hold_cnt;
    case (state)
      IDLE: begin
        if (rr_valid) begin
          state_nxt = GRANT;
          owner_nxt = rr_idx;
          last_nxt  = rr_idx;
          hold_nxt  = HOLD_RELOAD;
        end
      end
      GRANT: begin
        if (!bus.in_req[owner]) begin
          if (rr_valid) begin
            owner_nxt = rr_idx;
            last_nxt  = rr_idx;
            hold_nxt  = HOLD_RELOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else if (hold_cnt == '0 && other_req != 4'b0) begin
          // owner == last here, so the winner is always a competitor
          owner_nxt = rr_idx;
          last_nxt  = rr_idx;
          hold_nxt  = HOLD_RELOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase

    gnt_nxt  = 4'b0;
    busy_nxt = 1'b0;
    led_sel  = IDLE_PATTERN;
    if (state_nxt == GRANT) begin
      gnt_nxt  = 4'(1) << owner_nxt;
      busy_nxt = 1'b1;
      led_sel  = bus.in_pat[int'(owner_nxt)*LED_W +: LED_W];
    end
    led_nxt = led_sel ^ LED_XOR;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state        <= IDLE;
      owner        <= 2'd0;
      last         <= 2'd3;
      hold_cnt     <= '0;
      bus.out_gnt  <= 4'b0;
      bus.out_led  <= IDLE_PATTERN ^ LED_XOR;
      bus.out_busy <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      last         <= last_nxt;
      hold_cnt     <= hold_nxt;
      bus.out_gnt  <= gnt_nxt;
      bus.out_led  <= led_nxt;
      bus.out_busy <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - directed and randomized checks of led_arbiter against a reference model
module tb_led_arbiter;
  localparam int HOLD = 4;
  localparam int W    = 6;
`ifdef LED_ARB_ACTIVE_LOW_EN
  localparam logic [W-1:0] MASK = 6'h3F;
`else
  localparam logic [W-1:0] MASK = 6'h00;
`endif
  localparam logic [4*W-1:0] PAT0 = {6'h3C, 6'h0F, 6'h2A, 6'h15};

  logic in_clk;
  logic in_rst;
  led_arbiter_if #(.LED_W(W)) bus ();

  led_arbiter #(
    .HOLD_CYCLES (HOLD),
    .LED_W       (W),
    .IDLE_PATTERN(6'h00)
  ) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .bus   (bus)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: owner -1 means idle; hold measured as edges since the grant edge
  int m_owner = -1;
  int m_last  = 3;
  int m_gcyc  = 0;
  int cyc     = 0;
  logic [3:0]   exp_gnt;
  logic [W-1:0] exp_led;
  logic         exp_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int l);
    for (int k = 1; k <= 4; k++) begin
      if (r[(l + k) % 4]) return (l + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    cyc++;
    if (in_rst) begin
      m_owner = -1;
      m_last  = 3;
    end else begin
      w = rr_pick(bus.in_req, m_last);
      if (m_owner < 0 || !bus.in_req[m_owner]) begin
        m_owner = w;
        if (w >= 0) begin
          m_last = w;
          m_gcyc = cyc;
        end
      end else if (cyc - m_gcyc >= HOLD && w >= 0 && w != m_owner) begin
        m_owner = w;
        m_last  = w;
        m_gcyc  = cyc;
      end
    end
    exp_gnt  = (m_owner < 0) ? 4'b0 : 4'(1) << m_owner;
    exp_busy = (m_owner >= 0);
    exp_led  = ((m_owner < 0) ? 6'h00 : bus.in_pat[m_owner*W +: W]) ^ MASK;
  endtask

  task automatic step();
    @(posedge in_clk);
    model_edge();
    #1;
    check("model_gnt", 32'(bus.out_gnt), 32'(exp_gnt));
    check("model_led", 32'(bus.out_led), 32'(exp_led));
    check("model_busy", 32'(bus.out_busy), 32'(exp_busy));
  endtask

  logic [3:0] rot [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    in_rst     = 1'b1;
    bus.in_req = 4'b0001;
    bus.in_pat = PAT0;

    // 1: reset then first grant
    step();
    step();
    check("t1_rst_gnt", 32'(bus.out_gnt), 32'h0);
    check("t1_rst_led", 32'(bus.out_led), 32'(MASK));
    check("t1_rst_busy", 32'(bus.out_busy), 32'h0);
    in_rst = 1'b0;
    step();
    check("t1_gnt", 32'(bus.out_gnt), 32'h1);
    check("t1_led", 32'(bus.out_led), 32'(6'h15 ^ MASK));

    // 2: minimum hold against a competitor
    bus.in_req = 4'b0011;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("t2_hold", 32'(bus.out_gnt), 32'h1);
    end
    step();
    check("t2_gnt", 32'(bus.out_gnt), 32'h2);
    check("t2_led", 32'(bus.out_led), 32'(6'h2A ^ MASK));

    // 3: fairness with all requesting
    bus.in_req = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int i = 1; i <= 3; i++) step();
      check("t3_held", 32'(bus.out_gnt), 32'(r == 0 ? 4'b0010 : rot[r-1]));
      step();
      check("t3_rot", 32'(bus.out_gnt), 32'(rot[r]));
    end

    // 4: early release switches without idle cycle
    bus.in_req = 4'b0100;
    step();
    check("t4_gnt2", 32'(bus.out_gnt), 32'h4);
    bus.in_req = 4'b1000;
    step();
    check("t4_gnt3", 32'(bus.out_gnt), 32'h8);
    check("t4_led3", 32'(bus.out_led), 32'(6'h3C ^ MASK));
    bus.in_req = 4'b0000;
    step();
    check("t4_idle_gnt", 32'(bus.out_gnt), 32'h0);
    check("t4_idle_led", 32'(bus.out_led), 32'(MASK));
    check("t4_idle_busy", 32'(bus.out_busy), 32'h0);

    // 5: live pattern, sole requester, reset mid-grant
    bus.in_req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) bus.in_pat[W +: W] = 6'h01;
      step();
      check("t5_gnt", 32'(bus.out_gnt), 32'h2);
      if (i == 5) check("t5_live", 32'(bus.out_led), 32'(6'h01 ^ MASK));
    end
    in_rst = 1'b1;
    step();
    check("t5_rst_gnt", 32'(bus.out_gnt), 32'h0);
    check("t5_rst_led", 32'(bus.out_led), 32'(MASK));
    check("t5_rst_busy", 32'(bus.out_busy), 32'h0);
    in_rst     = 1'b0;
    bus.in_pat = PAT0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) bus.in_req[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) bus.in_pat = 24'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
